// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the clock divider bank: default counter width, the
// half-period terminal counts for the standard 100 MHz derived rates, and the
// maximum supported channel count.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 27;
  localparam int NCH_MAX       = 8;

  // Terminal count = f_clk / (2 * f_out) - 1, with f_clk = 100 MHz.
  localparam logic [CNT_W_DEFAULT-1:0] DIV_1HZ   = 27'd49_999_999;
  localparam logic [CNT_W_DEFAULT-1:0] DIV_2HZ   = 27'd24_999_999;
  localparam logic [CNT_W_DEFAULT-1:0] DIV_500HZ = 27'd99_999;
  localparam logic [CNT_W_DEFAULT-1:0] DIV_1P8HZ = 27'd27_777_777;

endpackage : clk_div_pkg

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: a counter running 0..div_act, a square-wave output that
// toggles at each terminal count, a tick on every rising edge, and a
// double-buffered divisor that only takes effect on a half-period boundary.
//
// Ports
//   clk_in   system clock
//   rst_n    asynchronous active-low reset
//   en_i     run enable; low holds the channel idle with clk_o = 0
//   clr_i    synchronous phase-align clear (overrides en_i)
//   we_i     divisor write strobe for this channel
//   div_i    new half-period terminal count
//   clk_o    divided square wave
//   tick_o   one-cycle pulse coincident with each clk_o rising edge
//   pend_o   a written divisor is waiting for the next boundary
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             terminal;

  // cnt never exceeds div_act because reloads only happen when cnt returns to
  // 0; the >= merely keeps the channel from running away if it ever did.
  assign terminal = (cnt_q >= div_act_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // otherwise synthesis infers a latch.
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    if (clr_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      // A write coincident with the clear skips the pending stage entirely.
      if (we_i) begin
        div_act_d  = div_i;
        div_pend_d = div_i;
      end else if (pend_q) begin
        div_act_d = div_pend_q;
      end
    end else begin
      if (!en_i) begin
        // Idle channel has no half period to protect: reload at once.
        cnt_d = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end else if (terminal) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // Placed last so a write landing on a boundary cycle stays pending for
      // the following boundary instead of being consumed now.
      if (we_i) begin
        div_pend_d = div_i;
        pend_d     = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule : clk_div_chan

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of NCH independent clock dividers producing square waves and tick
// enables from the board clock. Decodes the shared configuration port into
// per-channel write strobes and fans the phase-align clear out to all channels.
//
// Ports
//   clk_in    system clock (100 MHz)
//   rst_n     asynchronous active-low reset
//   ch_en     per-channel run enable
//   sync_clr  synchronous phase-align clear of all channels
//   cfg_we    divisor write strobe
//   cfg_ch    target channel; values >= NCH are ignored
//   cfg_div   new half-period terminal count
//   clk_out   divided square waves
//   tick      one-cycle pulse on each clk_out rising edge
//   pend      divisor written but not yet active
// -----------------------------------------------------------------------------
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                     NCH     = 4,
  parameter int                     CNT_W   = CNT_W_DEFAULT,
  parameter logic [NCH*CNT_W-1:0]   DIV_RST = {DIV_1P8HZ, DIV_500HZ, DIV_2HZ, DIV_1HZ}
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] ch_we;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    // Matching only indices below NCH makes out-of-range writes a no-op.
    assign ch_we[i] = cfg_we && (cfg_ch == 3'(i));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .en_i   (ch_en[i]),
      .clr_i  (sync_clr),
      .we_i   (ch_we[i]),
      .div_i  (cfg_div),
      .clk_o  (clk_out[i]),
      .tick_o (tick[i]),
      .pend_o (pend[i])
    );
  end

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Directed bench for clk_div_bank with small reset divisors {3,2,1,0}.
// Outputs are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int NCH   = 4;
  localparam int CNT_W = 27;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   ch_en;
  logic             sync_clr;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  clk_div_bank #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .DIV_RST ({27'd3, 27'd2, 27'd1, 27'd0})
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .clk_out  (clk_out),
    .tick     (tick),
    .pend     (pend)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NCH-1:0] clk_exp;
    logic [NCH-1:0] tick_exp;
  } vec_t;

  vec_t tbl [8];
  int   total = 0;
  int   bad   = 0;
  int   rel   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    rel++;
  endtask

  task automatic adv(input int k);
    while (rel < k) step();
  endtask

  task automatic write(input logic [2:0] ch, input logic [CNT_W-1:0] div);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = div;
  endtask

  task automatic sync_start(input logic with_we, input logic [2:0] ch,
                            input logic [CNT_W-1:0] div);
    sync_clr = 1'b1;
    if (with_we) write(ch, div);
    step();
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    rel      = 0;
  endtask

  initial begin
    // Edge n after reset release: channel with divisor d has clk = (n/(d+1))%2.
    tbl[0] = '{4'b0001, 4'b0001};
    tbl[1] = '{4'b0010, 4'b0010};
    tbl[2] = '{4'b0111, 4'b0101};
    tbl[3] = '{4'b1100, 4'b1000};
    tbl[4] = '{4'b1101, 4'b0001};
    tbl[5] = '{4'b1010, 4'b0010};
    tbl[6] = '{4'b1011, 4'b0001};
    tbl[7] = '{4'b0000, 4'b0000};

    rst_n    = 1'b1;
    ch_en    = 4'hF;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 3'd0;
    cfg_div  = '0;
    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_clk",  32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick),    32'h0);
    check("rst_pend", 32'(pend),    32'h0);

    // Reset defaults: periods 2, 4, 6, 8.
    #2 rst_n = 1'b1;
    rel = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      check($sformatf("dflt_clk_%0d", n + 1),  32'(clk_out), 32'(tbl[n].clk_exp));
      check($sformatf("dflt_tick_%0d", n + 1), 32'(tick),    32'(tbl[n].tick_exp));
      check($sformatf("dflt_pend_%0d", n + 1), 32'(pend),    32'h0);
    end

    // Runtime reload: div 4, write 1 mid half period.
    sync_start(1'b1, 3'd0, 27'd4);
    adv(4);  check("rl_clk_e4",  32'(clk_out[0]), 32'd0);
    adv(5);  check("rl_clk_e5",  32'(clk_out[0]), 32'd1);
             check("rl_tick_e5", 32'(tick[0]),    32'd1);
    adv(7);  write(3'd0, 27'd1);
    adv(8);  cfg_we = 1'b0;
             check("rl_pend_e8", 32'(pend[0]),    32'd1);
    adv(9);  check("rl_clk_e9",  32'(clk_out[0]), 32'd1);
             check("rl_pend_e9", 32'(pend[0]),    32'd1);
    adv(10); check("rl_clk_e10", 32'(clk_out[0]), 32'd0);
             check("rl_pend_e10", 32'(pend[0]),   32'd0);
    adv(11); check("rl_clk_e11", 32'(clk_out[0]), 32'd0);
    adv(12); check("rl_clk_e12", 32'(clk_out[0]), 32'd1);
             check("rl_tick_e12", 32'(tick[0]),   32'd1);
    adv(13); check("rl_tick_e13", 32'(tick[0]),   32'd0);
    adv(14); check("rl_clk_e14", 32'(clk_out[0]), 32'd0);

    // Double write (7 then 2), then a write on the terminal-count cycle.
    sync_start(1'b1, 3'd0, 27'd3);
    write(3'd0, 27'd7);
    adv(1);  write(3'd0, 27'd2);
    adv(2);  cfg_we = 1'b0;
             check("dw_pend_e2", 32'(pend[0]),    32'd1);
    adv(3);  check("dw_clk_e3",  32'(clk_out[0]), 32'd0);
    adv(4);  check("dw_clk_e4",  32'(clk_out[0]), 32'd1);
             check("dw_pend_e4", 32'(pend[0]),    32'd0);
    adv(6);  check("dw_clk_e6",  32'(clk_out[0]), 32'd1);
             write(3'd0, 27'd5);
    adv(7);  cfg_we = 1'b0;
             check("dw_clk_e7",  32'(clk_out[0]), 32'd0);
             check("dw_pend_e7", 32'(pend[0]),    32'd1);
    adv(9);  check("dw_clk_e9",  32'(clk_out[0]), 32'd0);
    adv(10); check("dw_clk_e10", 32'(clk_out[0]), 32'd1);
             check("dw_pend_e10", 32'(pend[0]),   32'd0);
    adv(15); check("dw_clk_e15", 32'(clk_out[0]), 32'd1);
    adv(16); check("dw_clk_e16", 32'(clk_out[0]), 32'd0);

    // ch_en toggle on ch1 (divisor 1) while its clk_out is high.
    sync_start(1'b0, 3'd0, '0);
    adv(2);  check("en_clk_e2",  32'(clk_out[1]), 32'd1);
             ch_en[1] = 1'b0;
             write(3'd1, 27'd3);
    adv(3);  cfg_we = 1'b0;
             check("en_clk_e3",  32'(clk_out[1]), 32'd0);
             check("en_tick_e3", 32'(tick[1]),    32'd0);
             check("en_pend_e3", 32'(pend[1]),    32'd1);
    adv(4);  check("en_pend_e4", 32'(pend[1]),    32'd0);
    adv(5);  ch_en[1] = 1'b1;
    adv(8);  check("en_clk_e8",  32'(clk_out[1]), 32'd0);
    adv(9);  check("en_clk_e9",  32'(clk_out[1]), 32'd1);
             check("en_tick_e9", 32'(tick[1]),    32'd1);

    // Pending ch3 write, then sync_clr with a concurrent ch2 write.
    write(3'd3, 27'd2);
    step();
    cfg_we = 1'b0;
    check("sc_pend_pre", 32'(pend), 32'b1000);
    sync_start(1'b1, 3'd2, 27'd9);
    check("sc_clk_e0",  32'(clk_out), 32'h0);
    check("sc_tick_e0", 32'(tick),    32'h0);
    check("sc_pend_e0", 32'(pend),    32'h0);
    adv(2);  check("sc_clk3_e2", 32'(clk_out[3]), 32'd0);
    adv(3);  check("sc_clk3_e3", 32'(clk_out[3]), 32'd1);
    adv(9);  check("sc_clk2_e9", 32'(clk_out[2]), 32'd0);
    adv(10); check("sc_clk2_e10", 32'(clk_out[2]), 32'd1);
             check("sc_tick2_e10", 32'(tick[2]),   32'd1);

    // Out-of-range write; divisors now ch0=5, ch1=3, ch2=9, ch3=2.
    sync_start(1'b0, 3'd0, '0);
    write(3'd5, 27'd0);
    adv(1);  cfg_we = 1'b0;
             check("oor_pend_e1", 32'(pend),    32'h0);
    adv(3);  check("oor_clk_e3",  32'(clk_out), 32'b1000);
    adv(4);  check("oor_clk_e4",  32'(clk_out), 32'b1010);
    adv(6);  check("oor_clk_e6",  32'(clk_out), 32'b0011);
             write(3'd2, 27'd0);
    adv(7);  cfg_we = 1'b0;
             check("ar_pend_pre", 32'(pend),    32'b0100);
             check("ar_clk_pre",  32'(clk_out), 32'b0011);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("ar_clk",  32'(clk_out), 32'h0);
    check("ar_tick", 32'(tick),    32'h0);
    check("ar_pend", 32'(pend),    32'h0);
    #2 rst_n = 1'b1;
    rel = 0;
    adv(1);  check("ar_rel_e1", 32'(clk_out), 32'(tbl[0].clk_exp));
    adv(4);  check("ar_rel_e4", 32'(clk_out), 32'(tbl[3].clk_exp));
             check("ar_rel_tick_e4", 32'(tick), 32'(tbl[3].tick_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clk_div_bank

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent clock dividers that derives slow square-wave clocks and single-cycle tick enables from the 100 MHz board clock. Each channel has a runtime-programmable divisor with glitch-free reload at the half-period boundary, a per-channel enable, and a bank-wide phase-align clear. It drives display multiplexing, blink and timekeeping logic, which consume either the square wave or, preferably, the tick as a clock enable.

## Interface
- NCH, 4: number of divider channels (1..8).
- CNT_W, 27: counter and divisor width in bits.
- DIV_RST, {DIV_1P8HZ, DIV_500HZ, DIV_2HZ, DIV_1HZ}: packed NCH*CNT_W reset divisors; channel i uses bits [i*CNT_W +: CNT_W].

- clk_in  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NCH  per-channel run enable.
- sync_clr  in  1  synchronous phase-align clear of all channels.
- cfg_we  in  1  divisor write strobe, one cycle.
- cfg_ch  in  3  target channel of the write.
- cfg_div  in  CNT_W  new half-period terminal count.
- clk_out  out  NCH  divided square waves.
- tick  out  NCH  one-cycle pulse on each clk_out rising edge.
- pend  out  NCH  divisor write accepted, not yet active.

## Operation
- Reset values: all counters 0, clk_out 0, tick 0, pend 0, active divisor = DIV_RST slice, pending divisor = DIV_RST slice.
- Per channel: counter counts 0..div_act. At cnt == div_act: cnt <= 0, clk_out toggles. Half period = div_act+1 cycles; f_out = f_clk / (2*(div_act+1)). div_act = 0 gives f_clk/2.
- tick[i] = 1 in exactly the cycle clk_out[i] goes 0->1; 0 otherwise. Never high while ch_en[i] = 0.
- ch_en[i] = 0: counter held 0, clk_out[i] forced 0, tick[i] 0. A pending divisor is applied on the next cycle (idle channel reloads immediately). Re-enable: first rising clk_out after div_act+1 enabled cycles.
- cfg_we with cfg_ch < NCH: div_pend[cfg_ch] <= cfg_div, pend[cfg_ch] <= 1. cfg_ch >= NCH: write ignored, no state change.
- Enabled channel with pend = 1: div_act <= div_pend and pend <= 0 at the next terminal-count cycle (same cycle as the toggle). Current half period always completes with the old divisor; no runt or stretched pulse.
- Write while pend = 1: overwrites div_pend; only the last value is applied.
- cfg_we in the same cycle as a terminal count on that channel: terminal count uses the old div_act/div_pend; new value becomes pending, applied at the following terminal count.
- sync_clr: every channel cnt <= 0, clk_out <= 0, tick <= 0; every pending divisor applied, pend <= 0. Priority: rst_n > sync_clr > ch_en > terminal count. cfg_we concurrent with sync_clr: written value becomes div_act directly, pend stays 0.
- Reset asserted mid-operation: all state to reset values immediately, regardless of clk_in.

## Timing
- All outputs registered; no combinational input-to-output path.
- cfg_we -> pend visible: 1 cycle.
- sync_clr asserted in cycle n -> outputs 0 in cycle n+1; first rising clk_out at cycle n+1+div_act+1.
- Reset release: counting starts on first clk_in edge after rst_n deassertion; first rising clk_out after DIV_RST+1 cycles (if ch_en high).
- Channels are fully independent; no phase relation except after sync_clr or a common reset.

## Structure
- Package clk_div_pkg: CNT_W default, DIV_1HZ = 49_999_999, DIV_2HZ = 24_999_999, DIV_500HZ = 99_999, DIV_1P8HZ = 27_777_777, NCH_MAX = 8.
- Sub-module clk_div_chan: one counter, div_act, div_pend, pend flag, clk_out, tick; instantiated NCH times by generate. Top decodes cfg_ch into per-channel write strobes and fans out sync_clr.

## Test plan
- Reset defaults (override DIV_RST = {3,2,1,0}, all ch_en = 1): clk_out periods 2, 4, 6, 8 cycles; tick once per period, coincident with rising edge.
- Runtime reload: ch0 div 4, write 1 mid half period -> pend = 1 next cycle; current half period lasts 5 cycles, subsequent ones 2; pend clears on the toggle cycle.
- Double write then write at terminal count: write 7, write 2 before terminal -> 2 applied; write 5 in terminal cycle -> applied one half period later.
- ch_en toggle: drop ch1 while clk_out high -> clk_out 0, tick 0 next cycle; re-enable with div 3 -> first rise after 4 cycles.
- sync_clr with cfg_we (ch2, div 9) same cycle: all outputs 0 next cycle; ch2 first rise 10 cycles later; pend all 0.
- Async reset mid-count and cfg_ch = 5 write: outputs 0 without a clock edge; out-of-range write leaves every div_act and pend unchanged.
